jtcop_sec_port: RTL and testbench

MCU-side end of the main-CPU/security-MCU mailbox. Receives the 16-bit word the 68000 latches with its write strobe, interrupts the 8-bit protection MCU, and exposes the word as two byte registers. Builds the MCU's 16-bit reply from two byte writes and drives it to the main CPU, raising the `sec2` edge that triggers the main CPU's level-5 interrupt. Sits between the main CPU's `sec[1:0]`/`mcu_din`/`mcu_dout`/`sec2` signals and the MCU core's I/O page.

---
 rtl/jtcop_sec_port.sv | 156 +++++++++++++++
 tb/tb_jtcop_sec_port.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/jtcop_sec_port.sv
// Main-CPU <-> security-MCU mailbox: command word in, two-byte reply out with sec2 handshake.
// Latency: strobe sampled at n acts at end of n+1; hu_dout valid n+2; sec2 rises n+3 after commit.
// Backpressure: none; an unread command is overwritten and flagged in ovr.
module jtcop_sec_port (
    input  logic        clk,
    input  logic        rst,
    input  logic        main_wr,
    input  logic        main_rd,
    input  logic [15:0] main_dout,
    output logic [15:0] mcu_dout,
    output logic        sec2,
    input  logic        hu_cs,
    input  logic        hu_we,
    input  logic [1:0]  hu_addr,
    input  logic [7:0]  hu_din,
    output logic [7:0]  hu_dout,
    output logic        hu_irqn
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REARM = 2'd1,
        PEND  = 2'd2
    } state_t;

    state_t      state, state_nxt;

    logic        wr_s, wr_d, rd_s, rd_d, hw_s, hw_d, hr_s, hr_d;
    logic [1:0]  addr_s;
    logic [7:0]  din_s;
    logic [15:0] word_s;

    logic [15:0] cmd;
    logic [7:0]  lo_stage;
    logic        cmd_full;
    logic        ovr;
    logic        pend;

    // Strobes and their qualifiers are captured together so each event uses
    // the address/data present when the strobe was first seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_s   <= 1'b0;
            wr_d   <= 1'b0;
            rd_s   <= 1'b0;
            rd_d   <= 1'b0;
            hw_s   <= 1'b0;
            hw_d   <= 1'b0;
            hr_s   <= 1'b0;
            hr_d   <= 1'b0;
            addr_s <= 2'd0;
            din_s  <= 8'd0;
            word_s <= 16'd0;
        end else begin
            wr_s   <= main_wr;
            wr_d   <= wr_s;
            rd_s   <= main_rd;
            rd_d   <= rd_s;
            hw_s   <= hu_cs & hu_we;
            hw_d   <= hw_s;
            hr_s   <= hu_cs & ~hu_we;
            hr_d   <= hr_s;
            addr_s <= hu_addr;
            din_s  <= hu_din;
            word_s <= main_dout;
        end
    end

    logic wr_ev, rd_ev, hw_ev, hr_ev;
    logic rd_hi, rd_stat, commit, abort;

    assign wr_ev   = wr_s & ~wr_d;
    assign rd_ev   = rd_s & ~rd_d;
    assign hw_ev   = hw_s & ~hw_d;
    assign hr_ev   = hr_s & ~hr_d;
    assign rd_hi   = hr_ev & (addr_s == 2'd1);
    assign rd_stat = hr_ev & (addr_s == 2'd2);
    assign commit  = hw_ev & (addr_s == 2'd1);
    assign abort   = hw_ev & (addr_s == 2'd2);

    assign pend    = (state != IDLE);
    assign sec2    = (state == PEND);
    assign hu_irqn = ~cmd_full;

    // A new word colliding with the high-byte read replaces the one being
    // consumed, so it is not counted as an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd      <= 16'd0;
            cmd_full <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            if (rd_stat)
                ovr <= 1'b0;
            if (wr_ev) begin
                cmd      <= word_s;
                cmd_full <= 1'b1;
                if (cmd_full && !rd_hi)
                    ovr <= 1'b1;
            end else if (rd_hi) begin
                cmd_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hu_dout <= 8'hff;
        end else if (hr_ev) begin
            case (addr_s)
                2'd0:    hu_dout <= cmd[7:0];
                2'd1:    hu_dout <= cmd[15:8];
                2'd2:    hu_dout <= {5'b0, ovr, pend, cmd_full};
                default: hu_dout <= mcu_dout[7:0];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lo_stage <= 8'd0;
            mcu_dout <= 16'd0;
        end else if (hw_ev) begin
            if (addr_s == 2'd0)
                lo_stage <= din_s;
            if (addr_s == 2'd1)
                mcu_dout <= {din_s, lo_stage};
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // REARM forces one low cycle on sec2 so every commit yields a fresh edge.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (commit) state_nxt = REARM;
            REARM:   state_nxt = PEND;
            PEND: begin
                if (commit)
                    state_nxt = REARM;
                else if (rd_ev)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort)
            state_nxt = IDLE;
    end

endmodule

// File: tb/tb_jtcop_sec_port.sv
// Directed bench for jtcop_sec_port: command path, overrun, reply handshake, collisions, abort, reset.
module tb_jtcop_sec_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        main_wr, main_rd;
    logic [15:0] main_dout;
    logic [15:0] mcu_dout;
    logic        sec2;
    logic        hu_cs, hu_we;
    logic [1:0]  hu_addr;
    logic [7:0]  hu_din;
    logic [7:0]  hu_dout;
    logic        hu_irqn;

    int total = 0;
    int bad   = 0;

    jtcop_sec_port dut (
        .clk       (clk),
        .rst       (rst),
        .main_wr   (main_wr),
        .main_rd   (main_rd),
        .main_dout (main_dout),
        .mcu_dout  (mcu_dout),
        .sec2      (sec2),
        .hu_cs     (hu_cs),
        .hu_we     (hu_we),
        .hu_addr   (hu_addr),
        .hu_din    (hu_din),
        .hu_dout   (hu_dout),
        .hu_irqn   (hu_irqn)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mcu_rd(input logic [1:0] a, output logic [7:0] d);
        hu_cs = 1'b1; hu_we = 1'b0; hu_addr = a;
        step(1);
        hu_cs = 1'b0;
        step(1);
        d = hu_dout;
    endtask

    task automatic mcu_wr(input logic [1:0] a, input logic [7:0] d);
        hu_cs = 1'b1; hu_we = 1'b1; hu_addr = a; hu_din = d;
        step(1);
        hu_cs = 1'b0; hu_we = 1'b0;
        step(1);
    endtask

    task automatic main_pulse(input logic [15:0] d);
        main_wr = 1'b1; main_dout = d;
        step(1);
        main_wr = 1'b0;
        step(2);
    endtask

    logic [7:0] rdat;

    initial begin
        rst = 1'b1; main_wr = 1'b0; main_rd = 1'b0; main_dout = 16'h0;
        hu_cs = 1'b0; hu_we = 1'b0; hu_addr = 2'd0; hu_din = 8'h0;
        step(3);
        rst = 1'b0;
        step(1);
        chk("rst_sec2", {15'b0, sec2}, 16'h0);
        chk("rst_irqn", {15'b0, hu_irqn}, 16'h1);
        chk("rst_hu_dout", {8'b0, hu_dout}, 16'h00ff);
        chk("rst_mcu_dout", mcu_dout, 16'h0000);

        // Command held four cycles: one event, irq falls at n+2
        main_wr = 1'b1; main_dout = 16'hA55A;
        step(1);
        chk("irq_n1", {15'b0, hu_irqn}, 16'h1);
        step(1);
        chk("irq_n2", {15'b0, hu_irqn}, 16'h0);
        step(2);
        main_wr = 1'b0;
        step(2);
        chk("irq_held", {15'b0, hu_irqn}, 16'h0);
        mcu_rd(2'd0, rdat); chk("cmd_lo", {8'b0, rdat}, 16'h005A);
        mcu_rd(2'd1, rdat); chk("cmd_hi", {8'b0, rdat}, 16'h00A5);
        chk("irq_clear", {15'b0, hu_irqn}, 16'h1);
        mcu_rd(2'd2, rdat); chk("stat_idle", {8'b0, rdat}, 16'h0000);

        // Overrun
        main_pulse(16'h1234);
        main_pulse(16'h5678);
        mcu_rd(2'd2, rdat); chk("stat_ovr", {8'b0, rdat}, 16'h0005);
        mcu_rd(2'd0, rdat); chk("ovr_lo", {8'b0, rdat}, 16'h0078);
        mcu_rd(2'd1, rdat); chk("ovr_hi", {8'b0, rdat}, 16'h0056);
        mcu_rd(2'd2, rdat); chk("stat_ovr_clr", {8'b0, rdat}, 16'h0000);

        // Reply handshake
        mcu_wr(2'd0, 8'hCD);
        hu_cs = 1'b1; hu_we = 1'b1; hu_addr = 2'd1; hu_din = 8'hAB;
        step(1);
        hu_cs = 1'b0; hu_we = 1'b0;
        step(1);
        chk("reply_word", mcu_dout, 16'hABCD);
        chk("reply_rearm", {15'b0, sec2}, 16'h0);
        step(1);
        chk("reply_sec2", {15'b0, sec2}, 16'h1);
        mcu_rd(2'd2, rdat); chk("stat_pend", {8'b0, rdat}, 16'h0002);
        mcu_rd(2'd3, rdat); chk("readback", {8'b0, rdat}, 16'h00CD);
        main_rd = 1'b1;
        step(1);
        main_rd = 1'b0;
        chk("rd_n1", {15'b0, sec2}, 16'h1);
        step(1);
        chk("rd_n2", {15'b0, sec2}, 16'h0);
        mcu_rd(2'd2, rdat); chk("stat_nopend", {8'b0, rdat}, 16'h0000);

        // Re-arm while pending
        mcu_wr(2'd0, 8'hEE);
        mcu_wr(2'd1, 8'hFF);
        step(1);
        chk("pend_again", {15'b0, sec2}, 16'h1);
        mcu_wr(2'd0, 8'h01);
        chk("pend_hold", {15'b0, sec2}, 16'h1);
        hu_cs = 1'b1; hu_we = 1'b1; hu_addr = 2'd1; hu_din = 8'h00;
        step(1);
        hu_cs = 1'b0; hu_we = 1'b0;
        chk("rearm_n1", {15'b0, sec2}, 16'h1);
        step(1);
        chk("rearm_low", {15'b0, sec2}, 16'h0);
        chk("rearm_word", mcu_dout, 16'h0001);
        step(1);
        chk("rearm_high", {15'b0, sec2}, 16'h1);

        // Collision: new command with high-byte read
        main_pulse(16'h1111);
        main_wr = 1'b1; main_dout = 16'hBEEF;
        hu_cs = 1'b1; hu_we = 1'b0; hu_addr = 2'd1;
        step(1);
        main_wr = 1'b0; hu_cs = 1'b0;
        step(1);
        chk("coll_hi_old", {8'b0, hu_dout}, 16'h0011);
        chk("coll_irqn", {15'b0, hu_irqn}, 16'h0);
        mcu_rd(2'd0, rdat); chk("coll_lo", {8'b0, rdat}, 16'h00EF);
        mcu_rd(2'd1, rdat); chk("coll_hi", {8'b0, rdat}, 16'h00BE);
        mcu_rd(2'd2, rdat); chk("coll_no_ovr", {8'b0, rdat}, 16'h0002);

        // Collision: commit with main_rd while pending
        main_rd = 1'b1;
        hu_cs = 1'b1; hu_we = 1'b1; hu_addr = 2'd1; hu_din = 8'h22;
        step(1);
        main_rd = 1'b0; hu_cs = 1'b0; hu_we = 1'b0;
        step(1);
        chk("crd_rearm", {15'b0, sec2}, 16'h0);
        chk("crd_word", mcu_dout, 16'h2201);
        step(1);
        chk("crd_sec2", {15'b0, sec2}, 16'h1);

        // Abort
        mcu_wr(2'd2, 8'h5A);
        chk("abort_low", {15'b0, sec2}, 16'h0);
        step(3);
        chk("abort_stay", {15'b0, sec2}, 16'h0);

        // Reset while in REARM with a command pending
        main_pulse(16'h4242);
        mcu_wr(2'd0, 8'h77);
        mcu_wr(2'd1, 8'h66);
        chk("pre_rst_irqn", {15'b0, hu_irqn}, 16'h0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rr_sec2", {15'b0, sec2}, 16'h0);
        chk("rr_irqn", {15'b0, hu_irqn}, 16'h1);
        chk("rr_hu_dout", {8'b0, hu_dout}, 16'h00ff);
        chk("rr_mcu_dout", mcu_dout, 16'h0000);
        step(3);
        chk("rr_no_edge", {15'b0, sec2}, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
